// File: rtl/axi4_lite_write_master_engine_if.sv
// AXI4-Lite write channels (AW, W, B) between
// the write master engine and a write slave.
interface axi4_lite_write_master_engine_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    input  awready, wready,
    input  bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    output awready, wready,
    output bvalid, bresp
  );
endinterface

// File: rtl/axi4_lite_write_master_engine.sv
// AXI4-Lite write initiator: one local command
// becomes one AW+W burst, B returns as rsp.
module axi4_lite_write_master_engine #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [2:0]               cmd_prot,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic [DATA_WIDTH/8-1:0]  cmd_strb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_resp,
  output logic                     timeout_err,
  axi4_lite_write_master_engine_if.master axi
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_B,
    RESP
  } state_t;

  state_t state, nxt;

  logic          aw_done, w_done;
  logic          awvalid, wvalid, bready;
  logic          accept, aw_hs, w_hs, b_hs;
  logic          busy;
  logic [CW-1:0] cnt;

  assign accept = cmd_valid & cmd_ready;
  assign aw_hs  = awvalid & axi.awready;
  assign w_hs   = wvalid & axi.wready;
  assign b_hs   = bready & axi.bvalid;
  assign busy   = (state == SEND) ||
                  (state == WAIT_B);

  assign axi.awvalid = awvalid;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

  // State register; reset drops every valid at once
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= nxt;
  end

  // Next state and handshake outputs decoded from state
  always_comb begin
    nxt       = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nxt = SEND;
      end
      SEND: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || axi.awready) &&
            (w_done || axi.wready))
          nxt = WAIT_B;
      end
      WAIT_B: begin
        bready = 1'b1;
        if (axi.bvalid) nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Per-channel completion flags, re-armed on accept
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Payload registers feed the bus directly
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axi.awaddr <= '0;
      axi.awprot <= '0;
      axi.wdata  <= '0;
      axi.wstrb  <= '0;
    end else if (accept) begin
      axi.awaddr <= cmd_addr;
      axi.awprot <= cmd_prot;
      axi.wdata  <= cmd_data;
      axi.wstrb  <= cmd_strb;
    end
  end

  // Response capture, held until rsp handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  rsp_resp <= '0;
    else if (b_hs) rsp_resp <= axi.bresp;
  end

  // Saturating watchdog; flag is sticky until reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (busy) begin
      if (cnt != TMO) cnt <= cnt + ONE;
      if (TIMEOUT_CYCLES != 0 && cnt == TMO - ONE)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_master_engine.sv
// Directed and randomized checks of the write
// master against a timeline model of each transfer.
module tb_axi4_lite_write_master_engine;

  localparam int TMO_P = 8;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_prot;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit err_exp = 0;

  axi4_lite_write_master_engine_if #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32)
  ) axi ();

  axi4_lite_write_master_engine #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO_P)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_prot(cmd_prot),
    .cmd_data(cmd_data),
    .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp),
    .timeout_err(timeout_err),
    .axi(axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'($urandom);
    rsp_ready   = 1'b0;
  endtask

  // Timeline (cycles after accept at 0):
  // AW hs at ta, W hs at tw, bready from
  // max(ta,tw)+1, B hs when bvalid meets bready,
  // rsp_valid the cycle after until rsp hs.
  task automatic txn(input logic [31:0] addr,
                     input logic [2:0]  prot,
                     input logic [31:0] data,
                     input logic [3:0]  strb,
                     input int aw_dly,
                     input int w_dly,
                     input int b_dly,
                     input logic [1:0]  br,
                     input int rsp_dly);
    int ta, tw, tb0, bv, tbh, tr, th;
    bit to;
    ta  = 1 + aw_dly;
    tw  = 1 + w_dly;
    tb0 = ((ta > tw) ? ta : tw) + 1;
    bv  = 1 + b_dly;
    tbh = (bv > tb0) ? bv : tb0;
    tr  = tbh + 1;
    th  = tr + rsp_dly;
    to  = (tbh >= TMO_P);
    @(negedge aclk);
    slave_idle();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_prot  = prot;
    cmd_data  = data;
    cmd_strb  = strb;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("awvalid_idle", axi.awvalid, 0);
    chk("timeout_idle", timeout_err, err_exp);
    @(posedge aclk);
    for (int n = 1; n <= th; n++) begin
      @(negedge aclk);
      cmd_valid    = 1'($urandom);
      cmd_addr     = $urandom;
      cmd_prot     = 3'($urandom);
      cmd_data     = $urandom;
      cmd_strb     = 4'($urandom);
      axi.awready  = (n >= ta);
      axi.wready   = (n >= tw);
      axi.bvalid   = (n >= bv) && (n <= tbh);
      axi.bresp    = (n >= bv) ? br : 2'($urandom);
      rsp_ready    = (n == th);
      chk("awvalid", axi.awvalid, n <= ta);
      chk("wvalid", axi.wvalid, n <= tw);
      chk("bready", axi.bready,
          (n >= tb0) && (n <= tbh));
      chk("rsp_valid", rsp_valid, n >= tr);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("timeout_err", timeout_err,
          err_exp || (to && n > TMO_P));
      if (n <= ta) begin
        chk("awaddr", axi.awaddr, addr);
        chk("awprot", axi.awprot, prot);
      end
      if (n <= tw) begin
        chk("wdata", axi.wdata, data);
        chk("wstrb", axi.wstrb, strb);
      end
      if (n >= tr) chk("rsp_resp", rsp_resp, br);
      @(posedge aclk);
    end
    if (to) err_exp = 1'b1;
  endtask

  task automatic rand_txn();
    txn($urandom, 3'($urandom), $urandom,
        ($urandom_range(0, 3) == 0) ? 4'h0
                                    : 4'($urandom),
        $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 5), 2'($urandom),
        $urandom_range(0, 2));
  endtask

  initial begin
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_prot  = '0;
    cmd_data  = '0;
    cmd_strb  = '0;
    slave_idle();
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", axi.wstrb, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    aresetn = 1'b1;

    // back-to-back at full speed
    txn(32'h10, 3'd0, 32'hA5A5A5A5, 4'hF,
        0, 0, 0, 2'b00, 0);
    txn(32'h14, 3'd0, 32'h5A5A5A5A, 4'hF,
        0, 0, 0, 2'b00, 0);
    // AW late, W early
    txn(32'h100, 3'd5, 32'h12345678, 4'h3,
        5, 0, 0, 2'b00, 0);
    // W late, AW early
    txn(32'h203, 3'd2, 32'hCAFEF00D, 4'h0,
        0, 3, 0, 2'b01, 0);
    // SLVERR, slow B, slow rsp_ready
    txn(32'h300, 3'd7, 32'hDEADBEEF, 4'h8,
        0, 0, 4, 2'b10, 3);
    repeat (16) rand_txn();
    // B withheld past the watchdog
    txn(32'h400, 3'd1, 32'h0BADF00D, 4'hF,
        1, 2, 20, 2'b11, 1);
    repeat (4) rand_txn();

    // reset while AW/W pending
    @(negedge aclk);
    slave_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h500;
    cmd_data  = 32'h55AA55AA;
    cmd_strb  = 4'hF;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("send_awvalid", axi.awvalid, 1);
    chk("send_wvalid", axi.wvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_awvalid", axi.awvalid, 0);
    chk("arst_wvalid", axi.wvalid, 0);
    chk("arst_bready", axi.bready, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_awaddr", axi.awaddr, 0);
    err_exp = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_awvalid", axi.awvalid, 0);
    txn(32'h600, 3'd3, 32'h13579BDF, 4'h5,
        1, 1, 2, 2'b00, 1);

    @(negedge aclk);
    cmd_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
